// File: rtl/npu_axi_lite_regfile.sv
// AXI4-Lite control/status register file for the NPU: independent AW/W capture,
// WSTRB-aware register updates, start/clear pulses, W1C interrupt status and level irq.
module npu_axi_lite_regfile #(
  parameter int          AXI_ADDR_WIDTH = 12,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          NUM_ARRAYS     = 4,
  parameter int          PES_PER_ARRAY  = 4,
  parameter logic [31:0] VERSION        = 32'h0002_0000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [AXI_ADDR_WIDTH-1:0]                   s_axi_awaddr,
  input  logic                                        s_axi_awvalid,
  output logic                                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]                   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]                 s_axi_wstrb,
  input  logic                                        s_axi_wvalid,
  output logic                                        s_axi_wready,
  output logic [1:0]                                  s_axi_bresp,
  output logic                                        s_axi_bvalid,
  input  logic                                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]                   s_axi_araddr,
  input  logic                                        s_axi_arvalid,
  output logic                                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]                   s_axi_rdata,
  output logic [1:0]                                  s_axi_rresp,
  output logic                                        s_axi_rvalid,
  input  logic                                        s_axi_rready,
  output logic                                        ctrl_start,
  output logic                                        ctrl_clear,
  output logic [NUM_ARRAYS-1:0]                       cluster_enable,
  output logic [NUM_ARRAYS-1:0][PES_PER_ARRAY-1:0]    pe_enable,
  output logic [31:0]                                 config_reg,
  output logic                                        irq,
  input  logic                                        status_busy,
  input  logic                                        status_done,
  input  logic                                        status_error
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int WA = AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [WA-1:0] W_CTRL    = WA'(0);
  localparam logic [WA-1:0] W_STATUS  = WA'(1);
  localparam logic [WA-1:0] W_IRQ     = WA'(2);
  localparam logic [WA-1:0] W_CLUSTER = WA'(3);
  localparam logic [WA-1:0] W_CONFIG  = WA'(4);
  localparam logic [WA-1:0] W_VERSION = WA'(5);
  localparam logic [WA-1:0] W_PE_BASE = WA'(64);

  // Handshake rule: a beat transfers on the rising edge where valid && ready are both 1;
  // valid is never dropped by this slave until its ready partner accepts it.

  logic               aw_held, w_held;
  logic [WA-1:0]      aw_addr_q;
  logic [DW-1:0]      w_data_q;
  logic [DW/8-1:0]    w_strb_q;
  logic               irq_en;
  logic [2:0]         irq_status;
  logic               done_d, err_d;

  logic               commit;
  logic [DW-1:0]      wmask;
  logic               wr_ok, wr_ctrl, wr_irq, wr_cluster, wr_config;
  logic [NUM_ARRAYS-1:0] wr_pe;
  logic [2:0]         irq_set, irq_clr;
  logic               ctrl_wr_lane0;

  logic [WA-1:0]      rd_word;
  logic [DW-1:0]      rd_data;
  logic               rd_err;

  // Byte-offset bits [1:0] are deliberately ignored by the decoder.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = !rst && !aw_held;
  assign s_axi_wready  = !rst && !w_held;
  assign s_axi_arready = !rst && !s_axi_rvalid;
  assign commit        = aw_held && w_held && !s_axi_bvalid;
  assign irq           = irq_en && (|irq_status);
  assign ctrl_wr_lane0 = commit && wr_ctrl && w_strb_q[0];

  always_comb begin
    wmask = '0;
    for (int k = 0; k < DW/8; k++) wmask[8*k +: 8] = {8{w_strb_q[k]}};
  end

  always_comb begin
    wr_ok      = 1'b1;
    wr_ctrl    = 1'b0;
    wr_irq     = 1'b0;
    wr_cluster = 1'b0;
    wr_config  = 1'b0;
    wr_pe      = '0;
    case (aw_addr_q)
      W_CTRL:              wr_ctrl    = 1'b1;
      W_STATUS, W_VERSION: wr_ok      = 1'b1;
      W_IRQ:               wr_irq     = 1'b1;
      W_CLUSTER:           wr_cluster = 1'b1;
      W_CONFIG:            wr_config  = 1'b1;
      default: begin
        wr_ok = 1'b0;
        for (int i = 0; i < NUM_ARRAYS; i++) begin
          if (aw_addr_q == W_PE_BASE + WA'(i)) begin
            wr_pe[i] = 1'b1;
            wr_ok    = 1'b1;
          end
        end
      end
    endcase
  end

  // New events win over a W1C landing on the same edge.
  always_comb begin
    irq_set = {ctrl_wr_lane0 && w_data_q[0] && status_busy,
               status_error && !err_d,
               status_done && !done_d};
    irq_clr = (commit && wr_irq) ? (w_data_q[2:0] & wmask[2:0]) : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      s_axi_bvalid   <= 1'b0;
      s_axi_bresp    <= RESP_OKAY;
      ctrl_start     <= 1'b0;
      ctrl_clear     <= 1'b0;
      irq_en         <= 1'b0;
      irq_status     <= 3'b000;
      done_d         <= 1'b0;
      err_d          <= 1'b0;
      cluster_enable <= '0;
      config_reg     <= '0;
      pe_enable      <= '1;
    end else begin
      done_d     <= status_done;
      err_d      <= status_error;
      irq_status <= (irq_status & ~irq_clr) | irq_set;
      ctrl_start <= 1'b0;
      ctrl_clear <= 1'b0;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (ctrl_wr_lane0) begin
          irq_en     <= w_data_q[2];
          ctrl_start <= w_data_q[0] && !status_busy;
          ctrl_clear <= w_data_q[1];
        end
        if (wr_cluster)
          cluster_enable <= (cluster_enable & ~wmask[NUM_ARRAYS-1:0]) |
                            (w_data_q[NUM_ARRAYS-1:0] & wmask[NUM_ARRAYS-1:0]);
        if (wr_config)
          config_reg <= (config_reg & ~wmask[31:0]) | (w_data_q[31:0] & wmask[31:0]);
        for (int i = 0; i < NUM_ARRAYS; i++) begin
          if (wr_pe[i])
            pe_enable[i] <= (pe_enable[i] & ~wmask[PES_PER_ARRAY-1:0]) |
                            (w_data_q[PES_PER_ARRAY-1:0] & wmask[PES_PER_ARRAY-1:0]);
        end
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  assign rd_word = s_axi_araddr[AXI_ADDR_WIDTH-1:2];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_word)
      W_CTRL:    rd_data = DW'({irq_en, 2'b00});
      W_STATUS:  rd_data = DW'({status_error, status_done, status_busy});
      W_IRQ:     rd_data = DW'(irq_status);
      W_CLUSTER: rd_data = DW'(cluster_enable);
      W_CONFIG:  rd_data = DW'(config_reg);
      W_VERSION: rd_data = DW'(VERSION);
      default: begin
        rd_err = 1'b1;
        for (int i = 0; i < NUM_ARRAYS; i++) begin
          if (rd_word == W_PE_BASE + WA'(i)) begin
            rd_data = DW'(pe_enable[i]);
            rd_err  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_data;
      s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_npu_axi_lite_regfile.sv
// Directed bench for npu_axi_lite_regfile: expected B/R responses are queued at issue
// time and checked by a monitor on each handshake; side outputs are checked inline.
module tb_npu_axi_lite_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [11:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic        ctrl_start, ctrl_clear, irq;
  logic [3:0]  cluster_enable;
  logic [3:0][3:0] pe_enable;
  logic [31:0] config_reg;
  logic        status_busy = 1'b0, status_done = 1'b0, status_error = 1'b0;

  npu_axi_lite_regfile dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .ctrl_start(ctrl_start), .ctrl_clear(ctrl_clear), .cluster_enable(cluster_enable),
    .pe_enable(pe_enable), .config_reg(config_reg), .irq(irq),
    .status_busy(status_busy), .status_done(status_done), .status_error(status_error)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int clear_cnt = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];

  always @(negedge clk) begin
    if (ctrl_start) start_cnt++;
    if (ctrl_clear) clear_cnt++;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [1:0]  eb;
    logic [33:0] er;
    if (!rst) begin
      if (s_axi_bvalid && s_axi_bready) begin
        n_vec++;
        if (exp_b_q.size() == 0) begin
          n_err++;
          $display("FAIL b_unexpected: got bresp %0h, required no response", s_axi_bresp);
        end else begin
          eb = exp_b_q.pop_front();
          if (s_axi_bresp !== eb) begin
            n_err++;
            $display("FAIL bresp: got %0h, required %0h", s_axi_bresp, eb);
          end
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        n_vec++;
        if (exp_r_q.size() == 0) begin
          n_err++;
          $display("FAIL r_unexpected: got %0h/%0h, required no response", s_axi_rresp, s_axi_rdata);
        end else begin
          er = exp_r_q.pop_front();
          if ({s_axi_rresp, s_axi_rdata} !== er) begin
            n_err++;
            $display("FAIL rdata: got resp %0h data %08h, required resp %0h data %08h",
                     s_axi_rresp, s_axi_rdata, er[33:32], er[31:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input bit expect_b);
    bit aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
    int t = 0;
    if (expect_b) exp_b_q.push_back(resp);
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done)) begin
      if (t > 50) begin
        n_vec++; n_err++;
        $display("FAIL aw_w_handshake_timeout: got no accept, required accept at addr %03h", a);
        break;
      end
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      tick();
      t++;
      if (aw_fire) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1'b1;  s_axi_wvalid = 1'b0;  end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
  endtask

  task automatic wait_b();
    int t = 0;
    while (exp_b_q.size() != 0 && t < 40) begin tick(); t++; end
    if (exp_b_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL b_timeout: got %0d pending, required 0", exp_b_q.size());
      exp_b_q.delete();
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp);
    axi_write(a, d, s, resp, 1'b1);
    wait_b();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp);
    int t = 0;
    exp_r_q.push_back({resp, d});
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && t < 50) begin tick(); t++; end
    tick();
    s_axi_arvalid = 1'b0;
    chk("rvalid_one_cycle_after_ar", s_axi_rvalid, 1);
    t = 0;
    while (exp_r_q.size() != 0 && t < 40) begin tick(); t++; end
    if (exp_r_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL r_timeout: got %0d pending, required 0", exp_r_q.size());
      exp_r_q.delete();
    end
  endtask

  initial begin
    bit stable;
    int t;
    // reset
    repeat (3) tick();
    chk("awready_in_reset", s_axi_awready, 0);
    chk("arready_in_reset", s_axi_arready, 0);
    rst = 1'b0;
    tick();
    chk("pe_enable_reset", pe_enable, 16'hFFFF);
    chk("cluster_reset", cluster_enable, 0);
    chk("irq_reset", irq, 0);
    chk("config_reset", config_reg, 0);
    chk("valid_reset", {s_axi_bvalid, s_axi_rvalid, ctrl_start, ctrl_clear}, 0);
    rd(12'h014, 32'h0002_0000, 2'b00);

    // W first, AW three cycles later, byte strobes 0101
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
    chk("wready_idle", s_axi_wready, 1);
    tick();
    s_axi_wvalid = 1'b0;
    repeat (2) tick();
    s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1;
    exp_b_q.push_back(2'b00);
    tick();
    s_axi_awvalid = 1'b0;
    chk("bvalid_not_early", s_axi_bvalid, 0);
    tick();
    chk("bvalid_two_after_aw", s_axi_bvalid, 1);
    chk("config_strb", config_reg, 32'h00AD00EF);
    wait_b();

    // start / clear pulses and busy rejection
    wr(12'h000, 32'h1, 4'hF, 2'b00);
    chk("start_pulse_once", start_cnt, 1);
    status_busy = 1'b1;
    wr(12'h000, 32'h2, 4'hF, 2'b00);
    chk("clear_while_busy", clear_cnt, 1);
    wr(12'h000, 32'h1, 4'hF, 2'b00);
    chk("start_rejected_no_pulse", start_cnt, 1);
    rd(12'h008, 32'h4, 2'b00);
    chk("irq_masked", irq, 0);
    wr(12'h000, 32'h4, 4'hF, 2'b00);
    chk("irq_enabled", irq, 1);
    rd(12'h000, 32'h4, 2'b00);
    status_busy = 1'b0;
    wr(12'h000, 32'h1, 4'b1110, 2'b00);
    chk("start_needs_lane0", start_cnt, 1);
    rd(12'h000, 32'h4, 2'b00);
    wr(12'h008, 32'h4, 4'hF, 2'b00);
    rd(12'h008, 32'h0, 2'b00);
    chk("irq_after_w1c", irq, 0);

    // done event, set wins over same-edge W1C
    status_done = 1'b1;
    repeat (2) tick();
    rd(12'h008, 32'h1, 2'b00);
    chk("irq_done", irq, 1);
    status_done = 1'b0;
    repeat (2) tick();
    exp_b_q.push_back(2'b00);
    s_axi_awaddr = 12'h008; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    status_done = 1'b1;
    tick();
    wait_b();
    rd(12'h008, 32'h1, 2'b00);
    wr(12'h008, 32'h1, 4'hF, 2'b00);
    rd(12'h008, 32'h0, 2'b00);
    chk("irq_cleared", irq, 0);

    // error event, strb=0 leaves W1C untouched
    status_error = 1'b1;
    repeat (2) tick();
    rd(12'h008, 32'h2, 2'b00);
    wr(12'h008, 32'h2, 4'h0, 2'b00);
    rd(12'h008, 32'h2, 2'b00);
    wr(12'h008, 32'h2, 4'h1, 2'b00);
    rd(12'h008, 32'h0, 2'b00);
    status_error = 1'b0;

    // status, cluster, PE enables
    status_busy = 1'b1;
    tick();
    rd(12'h004, 32'h3, 2'b00);
    wr(12'h004, 32'hFFFF_FFFF, 4'hF, 2'b00);
    rd(12'h004, 32'h3, 2'b00);
    status_busy = 1'b0;
    wr(12'h014, 32'h0, 4'hF, 2'b00);
    rd(12'h014, 32'h0002_0000, 2'b00);
    wr(12'h00C, 32'hFF, 4'hF, 2'b00);
    chk("cluster_written", cluster_enable, 4'hF);
    rd(12'h00C, 32'hF, 2'b00);
    wr(12'h104, 32'hFFFF_FFF5, 4'h1, 2'b00);
    chk("pe1_written", pe_enable, 16'hFF5F);
    rd(12'h104, 32'h5, 2'b00);

    // unmapped accesses
    wr(12'h110, 32'h0, 4'hF, 2'b10);
    rd(12'h110, 32'h0, 2'b10);
    wr(12'h020, 32'h1234_5678, 4'hF, 2'b10);
    rd(12'h020, 32'h0, 2'b10);
    chk("pe_after_unmapped", pe_enable, 16'hFF5F);
    chk("config_after_unmapped", config_reg, 32'h00AD00EF);

    // B backpressure with a second write queued
    s_axi_bready = 1'b0;
    axi_write(12'h010, 32'h1111_1111, 4'hF, 2'b00, 1'b1);
    axi_write(12'h010, 32'h2222_2222, 4'hF, 2'b00, 1'b1);
    stable = 1'b1;
    repeat (5) begin
      if (!(s_axi_bvalid === 1'b1 && s_axi_bresp === 2'b00)) stable = 1'b0;
      tick();
    end
    chk("bvalid_held_under_backpressure", stable, 1);
    chk("second_write_blocked", config_reg, 32'h1111_1111);
    s_axi_bready = 1'b1;
    wait_b();
    chk("second_write_after_b", config_reg, 32'h2222_2222);

    // reset while a response is pending
    s_axi_bready = 1'b0;
    axi_write(12'h010, 32'h3333_3333, 4'hF, 2'b00, 1'b0);
    t = 0;
    while (!s_axi_bvalid && t < 10) begin tick(); t++; end
    chk("bvalid_before_reset", s_axi_bvalid, 1);
    rst = 1'b1;
    #1;
    chk("bvalid_reset_mid", s_axi_bvalid, 0);
    chk("outputs_reset_mid", {config_reg, cluster_enable, irq, ctrl_start, s_axi_awready},
        {32'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    chk("pe_reset_mid", pe_enable, 16'hFFFF);
    repeat (2) tick();
    rst = 1'b0;
    s_axi_bready = 1'b1;
    repeat (5) tick();
    rd(12'h010, 32'h0, 2'b00);
    chk("queues_drained", exp_b_q.size() + exp_r_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/npu_axi_lite_regfile.md
# npu_axi_lite_regfile

Parametrised AXI4-Lite control/status register file for the NPU, successor to the fixed 4-array control slave. Accepts AW and W independently, honours WSTRB, flags unmapped accesses with SLVERR, and scales cluster/PE enable registers with NUM_ARRAYS and PES_PER_ARRAY. Adds one-cycle start/clear pulses with busy-rejection, sticky W1C interrupt status and a level interrupt output. Sits between the host AXI4-Lite interconnect and the NPU top-level controller.

## Interface
- AXI_ADDR_WIDTH, 12: byte address width; decode uses bits [AXI_ADDR_WIDTH-1:2], bits [1:0] ignored.
- AXI_DATA_WIDTH, 32: data width; only 32 supported.
- NUM_ARRAYS, 4: number of large arrays, 1..16.
- PES_PER_ARRAY, 4: PEs per array, 1..32.
- VERSION, 32'h0002_0000: value returned by VERSION register.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axi_aw{addr,valid,ready}, s_axi_w{data,strb,valid,ready}, s_axi_b{resp,valid,ready}, s_axi_ar{addr,valid,ready}, s_axi_r{data,resp,valid,ready}: standard AXI4-Lite slave, widths per parameters (strb 4, resp 2).
- ctrl_start  out  1  one-cycle start pulse.
- ctrl_clear  out  1  one-cycle clear pulse.
- cluster_enable  out  NUM_ARRAYS  per-array enable.
- pe_enable  out  NUM_ARRAYS x PES_PER_ARRAY  per-PE enable, packed [array][pe].
- config_reg  out  32  free-form configuration word.
- irq  out  1  level interrupt.
- status_busy, status_done, status_error  in  1 each  NPU status levels.

## Operation
- Register map (byte offsets): 0x000 CTRL: bit0 start (W1 pulse, reads 0), bit1 clear (W1 pulse, reads 0), bit2 irq_en (RW). 0x004 STATUS RO: {error,done,busy} in bits[2:0]. 0x008 IRQ_STATUS W1C: bit0 done_evt, bit1 err_evt, bit2 start_rejected. 0x00C CLUSTER_EN RW bits[NUM_ARRAYS-1:0]. 0x010 CONFIG RW 32 bits. 0x014 VERSION RO. 0x100+4*i PE_EN[i], i<NUM_ARRAYS, RW bits[PES_PER_ARRAY-1:0].
- Unimplemented bits read 0, writes to them ignored.
- Any other offset, including PE_EN[i] with i>=NUM_ARRAYS: write ignored, BRESP=2'b10; read returns 0, RRESP=2'b10. Writes to STATUS/VERSION: ignored, BRESP OKAY.
- WSTRB: byte lane k updates bits [8k+7:8k] only if strb[k]=1; applies to RW and W1C. CTRL pulses require strb[0]. strb=0 -> no change, OKAY.
- Start write while status_busy=1: no ctrl_start pulse, IRQ_STATUS.start_rejected set. Clear is never rejected.
- done_evt set on rising edge of status_done, err_evt on rising edge of status_error (compared against 1-cycle-delayed copy). Set beats W1C on the same edge.
- irq = CTRL.irq_en & |IRQ_STATUS[2:0].

## Timing
- Reset: awready/wready/arready 0 while rst=1, 1 after; bvalid, rvalid, bresp, rresp, rdata, ctrl_start, ctrl_clear, irq, cluster_enable, config_reg, all IRQ/CTRL bits 0; pe_enable all ones. Reset mid-transaction drops it; no B/R issued.
- Write path: one-entry AW holding reg and one-entry W holding reg; awready = !aw_held, wready = !w_held. AW and W may arrive in any order or same cycle.
- Commit on the edge where aw_held & w_held & !bvalid: registers update, holds clear, bvalid=1 from next cycle with bresp. AW+W handshaked in cycle T -> commit edge ending T+1 -> bvalid in T+2. bvalid holds until bready; new commit only after bvalid drops.
- ctrl_start/ctrl_clear high exactly the cycle after the commit edge (same cycle bvalid first rises).
- Read path: arready = !rvalid. AR handshake in T -> rdata/rresp registered at that edge, rvalid in T+1, held stable until rready. Back-to-back reads: one per 2 cycles minimum with rready=1.
- Read and write paths independent; a read sampled on a commit edge returns pre-write value.
- Reading IRQ_STATUS has no side effect.

## Test plan
- Reset release -> pe_enable all 1s, cluster_enable 0, irq 0; read 0x014 -> 0x0002_0000, RRESP 0, rvalid exactly 1 cycle after AR.
- W in cycle 2, AW in cycle 5 to 0x010 data 0xDEADBEEF strb 4'b0101 -> config_reg 0x00AD00EF, bvalid in cycle 7, BRESP 0.
- Write 0x000 data 0x1, busy=0 -> ctrl_start high exactly one cycle; repeat with busy=1 -> no pulse, IRQ_STATUS=0x4; with irq_en=1 irq=1.
- Pulse status_done 0->1 -> IRQ_STATUS bit0=1; W1C 0x1 on the same edge as a second done rising edge -> bit0 stays 1; later W1C 0x1 alone -> 0, irq 0.
- Write/read 0x100+4*NUM_ARRAYS and 0x020 -> BRESP/RRESP 2'b10, rdata 0, no register changes.
- Hold bready=0 for 5 cycles with second AW+W pending -> bvalid stable, second write commits only after first B handshake; assert rst mid-wait -> all outputs return to reset values.
